// File: rtl/soc_aead_pkg.sv
// Shared types and sizing helpers for the host-side sequencer of the
// byte-lane SoC decryption wrapper.
package soc_aead_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RST,
        LOAD,
        START,
        WAIT,
        READ,
        DONE
    } host_state_e;

    // The wrapper's load and output counters only clear on reset, so every
    // request starts with this many cycles of wrapper reset.
    localparam int RST_CYCLES = 2;

    function automatic int maxOf(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    function automatic int nLoad(input int k, input int l, input int y);
        return maxOf(maxOf(k, 128), maxOf(l, y)) / 8;
    endfunction

    function automatic int nOutBytes(input int y);
        return y / 8 + 16;
    endfunction

endpackage

// File: rtl/soc_decryption_host.sv
// Initiator on the wrapper strobe protocol: resets the wrapper, loads the
// request as 32-bit lane words, starts it, then reads plaintext and tag back.
module soc_decryption_host
    import soc_aead_pkg::*;
#(
    parameter int K       = 128,
    parameter int L       = 64,
    parameter int Y       = 128,
    parameter int TIMEOUT = 1024
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [K-1:0]   key_in,
    input  logic [127:0]   nonce_in,
    input  logic [L-1:0]   ad_in,
    input  logic [Y-1:0]   ct_in,
    input  logic [127:0]   tag_exp,
    output logic           busy,
    output logic           done,
    output logic           err,
    output logic           tag_ok,
    output logic [Y-1:0]   pt_out,
    output logic [127:0]   tag_out,
    output logic           soc_rstn,
    output logic           soc_input_ss,
    output logic [31:0]    soc_input,
    output logic           soc_start_ss,
    output logic           soc_start,
    input  logic           soc_ready,
    output logic           soc_out_ss,
    input  logic [7:0]     soc_byte
);

    localparam int N_LD = nLoad(K, L, Y);
    localparam int NB   = nOutBytes(Y);
    localparam int KB   = K / 8;
    localparam int LB   = L / 8;
    localparam int YB   = Y / 8;
    localparam int TW   = $clog2(TIMEOUT + 1);

    host_state_e     state_q;
    logic [7:0]      cnt_q;
    logic [TW-1:0]   waitCnt_q;

    logic [K-1:0]    key_q;
    logic [127:0]    nonce_q;
    logic [L-1:0]    ad_q;
    logic [Y-1:0]    ct_q;
    logic [127:0]    tagExp_q;

    logic [Y-1:0]    pt_q;
    logic [127:0]    tag_q;
    logic            busy_q;
    logic            done_q;
    logic            err_q;
    logic            tagOk_q;

    logic            socRstn_q;
    logic            inputSs_q;
    logic [31:0]     input_q;
    logic            startSs_q;
    logic            start_q;
    logic            outSs_q;

    logic [7:0]      ldIdx_d;
    logic [7:0]      keyLane_d;
    logic [7:0]      nonceLane_d;
    logic [7:0]      adLane_d;
    logic [7:0]      ctLane_d;
    logic [31:0]     loadWord_d;
    logic [Y+7:0]    ptShift_d;
    logic [135:0]    tagShift_d;

    // The word being registered is the one for the next LOAD cycle; lanes
    // whose field has run out of bytes stay zero.
    always_comb begin
        ldIdx_d     = (state_q == LOAD) ? (cnt_q + 8'd1) : 8'd0;
        keyLane_d   = '0;
        nonceLane_d = '0;
        adLane_d    = '0;
        ctLane_d    = '0;
        for (int b = 0; b < KB; b++)
            if (ldIdx_d == 8'(b)) keyLane_d = key_q[K-1-8*b -: 8];
        for (int b = 0; b < 16; b++)
            if (ldIdx_d == 8'(b)) nonceLane_d = nonce_q[127-8*b -: 8];
        for (int b = 0; b < LB; b++)
            if (ldIdx_d == 8'(b)) adLane_d = ad_q[L-1-8*b -: 8];
        for (int b = 0; b < YB; b++)
            if (ldIdx_d == 8'(b)) ctLane_d = ct_q[Y-1-8*b -: 8];
        loadWord_d = {ctLane_d, adLane_d, nonceLane_d, keyLane_d};
        ptShift_d  = {pt_q, soc_byte};
        tagShift_d = {tag_q, soc_byte};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            waitCnt_q <= '0;
            key_q     <= '0;
            nonce_q   <= '0;
            ad_q      <= '0;
            ct_q      <= '0;
            tagExp_q  <= '0;
            pt_q      <= '0;
            tag_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            tagOk_q   <= 1'b0;
            socRstn_q <= 1'b0;
            inputSs_q <= 1'b0;
            input_q   <= '0;
            startSs_q <= 1'b0;
            start_q   <= 1'b0;
            outSs_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        key_q     <= key_in;
                        nonce_q   <= nonce_in;
                        ad_q      <= ad_in;
                        ct_q      <= ct_in;
                        tagExp_q  <= tag_exp;
                        pt_q      <= '0;
                        tag_q     <= '0;
                        err_q     <= 1'b0;
                        tagOk_q   <= 1'b0;
                        busy_q    <= 1'b1;
                        socRstn_q <= 1'b0;
                        cnt_q     <= '0;
                        state_q   <= RST;
                    end else begin
                        socRstn_q <= 1'b1;
                    end
                end

                RST: begin
                    if (cnt_q == 8'(RST_CYCLES - 1)) begin
                        socRstn_q <= 1'b1;
                        inputSs_q <= 1'b1;
                        input_q   <= loadWord_d;
                        cnt_q     <= '0;
                        state_q   <= LOAD;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end

                LOAD: begin
                    if (cnt_q == 8'(N_LD - 1)) begin
                        inputSs_q <= 1'b0;
                        input_q   <= '0;
                        startSs_q <= 1'b1;
                        start_q   <= 1'b1;
                        state_q   <= START;
                    end else begin
                        input_q <= loadWord_d;
                        cnt_q   <= cnt_q + 8'd1;
                    end
                end

                START: begin
                    startSs_q <= 1'b0;
                    start_q   <= 1'b0;
                    waitCnt_q <= '0;
                    state_q   <= WAIT;
                end

                // Ready wins over timeout on the last allowed WAIT cycle.
                WAIT: begin
                    if (soc_ready) begin
                        outSs_q <= 1'b1;
                        cnt_q   <= '0;
                        state_q <= READ;
                    end else if (waitCnt_q == TW'(TIMEOUT - 1)) begin
                        err_q   <= 1'b1;
                        tagOk_q <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        waitCnt_q <= waitCnt_q + TW'(1);
                    end
                end

                // The byte strobed in cycle c arrives registered in cycle c+1,
                // so capture trails the strobe by one count.
                READ: begin
                    outSs_q <= ((cnt_q + 8'd1) < 8'(NB));
                    cnt_q   <= cnt_q + 8'd1;
                    if (cnt_q != 8'd0) begin
                        if (cnt_q <= 8'(YB)) pt_q <= ptShift_d[Y-1:0];
                        else                 tag_q <= tagShift_d[127:0];
                    end
                    if (cnt_q == 8'(NB)) begin
                        tagOk_q <= (tagShift_d[127:0] == tagExp_q) && !err_q;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end
                end

                DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end

                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy         = busy_q;
    assign done         = done_q;
    assign err          = err_q;
    assign tag_ok       = tagOk_q;
    assign pt_out       = pt_q;
    assign tag_out      = tag_q;
    assign soc_rstn     = socRstn_q;
    assign soc_input_ss = inputSs_q;
    assign soc_input    = input_q;
    assign soc_start_ss = startSs_q;
    assign soc_start    = start_q;
    assign soc_out_ss   = outSs_q;

endmodule

// File: doc/soc_decryption_host.md
# soc_decryption_host

Host-side sequencer that drives the byte-lane SoC decryption wrapper from a parallel request interface. It resets the wrapper, streams key/nonce/associated data/ciphertext as 32-bit load words, pulses start, waits for completion, then strobes out plaintext and tag bytes. It reassembles them into parallel registers and checks the tag against an expected value. It is the initiator on the wrapper's strobe protocol.

## Interface
- K, 128, key width in bits; multiple of 8, ≤248
- L, 64, associated-data width in bits; multiple of 8, ≤248
- Y, 128, ciphertext/plaintext width in bits; multiple of 8, ≤248
- TIMEOUT, 1024, maximum cycles spent in WAIT
- clk  in  1  clock; one clock domain
- rst  in  1  asynchronous, active-high reset
- start  in  1  request; accepted only in IDLE
- key_in  in  K  key, latched on accept
- nonce_in  in  128  nonce, latched on accept
- ad_in  in  L  associated data, latched on accept
- ct_in  in  Y  ciphertext, latched on accept
- tag_exp  in  128  expected tag, latched on accept
- busy  out  1  high from accept until done
- done  out  1  one-cycle completion pulse
- err  out  1  timeout flag, valid while done=1, held until next accept
- tag_ok  out  1  tag equals tag_exp, valid while done=1, held
- pt_out  out  Y  recovered plaintext
- tag_out  out  128  computed tag
- soc_rstn  out  1  active-low wrapper reset
- soc_input_ss  out  1  load-word strobe (wrapper reg_inputxSS)
- soc_input  out  32  load word (wrapper inputxSI)
- soc_start_ss  out  1  start select (wrapper reg_startxSS)
- soc_start  out  1  start pulse (wrapper decryption_startxSI)
- soc_ready  in  1  wrapper decryption_readyxSO, level
- soc_out_ss  out  1  output-byte strobe (wrapper reg_outxSS)
- soc_byte  in  8  wrapper plain_tagxSO, registered byte

## Operation
- Derived constants:
  - N_LD = max(K,128,L,Y)/8, the number of load words.
  - NB = Y/8 + 16, the number of output bytes.
- State IDLE:
  - soc_rstn=1 and all strobes are 0.
  - start=1: latch the inputs, clear pt_out, tag_out, err and tag_ok, set busy, then go to RST.
- State RST: 2 cycles with soc_rstn=0, then go to LOAD. Every request re-resets the wrapper because its load and output counters clear only on reset.
- State LOAD: N_LD cycles with soc_input_ss=1. Word n (n=0..N_LD-1) is built per lane, MSB byte first:
  - [7:0] = key byte n
  - [15:8] = nonce byte n
  - [23:16] = ad byte n
  - [31:24] = ct byte n
  - A lane whose field is shorter than n+1 bytes carries 0x00.
- State START: 1 cycle with soc_start_ss=1 and soc_start=1, then go to WAIT.
- State WAIT:
  - soc_ready=1 → go to READ.
  - TIMEOUT cycles elapsed without soc_ready → set err, go to DONE.
- State READ: counter c runs 0..NB.
  - soc_out_ss=1 while c<NB.
  - When c≥1, soc_byte is captured as byte c-1.
  - Bytes 0..Y/8-1 fill pt_out MSB first; bytes Y/8..NB-1 fill tag_out MSB first.
  - Exactly NB strobes are issued and none extra, then go to DONE.
- State DONE: done=1 for 1 cycle and tag_ok = (tag_out==tag_exp) && !err. Clear busy and return to IDLE.
- start outside IDLE is ignored and not queued.

## Timing
- Reset values:
  - busy, done, err and tag_ok are 0.
  - pt_out and tag_out are 0.
  - All strobes are 0 and soc_input=0.
  - soc_rstn=0, so the wrapper is held in reset; state is IDLE.
- soc_rstn rises on the first clock after rst deasserts.
- Outputs are registered. The strobes, soc_input and soc_rstn are decoded from registered state and counters only; they never depend combinationally on soc_ready or soc_byte.
- soc_byte is sampled exactly one cycle after its strobe.
- Latency from accept edge to the done cycle is 2 + N_LD + 1 + W + NB + 1, where W is the number of WAIT cycles. With defaults this is 52 + W.
- Timeout: err rises on the cycle after WAIT cycle TIMEOUT, and soc_out_ss is never asserted in that case.
- rst asserted mid-operation: immediate abort to the reset values, no done pulse, and the wrapper is held in reset.
- soc_ready already high on the first WAIT cycle: READ starts on the next cycle, so W=1.

## Structure
- Package soc_aead_pkg holds:
  - the state enum (IDLE, RST, LOAD, START, WAIT, READ, DONE)
  - the max/N_LD/NB constant functions
  - the wrapper reset length of 2
- Single module; no sub-module. Load-word lane selection is an indexed byte select inside the module.

## Test plan
- Load formatting: key=0x000102…0F, nonce=0x101112…1F, ad=0x2021…27, ct=0x3031…3F. Required load words:
  - word0 = 0x30201000
  - word7 = 0x37271707
  - word8 = 0x38001808
  - word15 = 0x3F001F0F
  - exactly 16 soc_input_ss cycles
- End-to-end with the wrapper and decryption core against the ASCON-128 golden vector. pt_out and tag_out must match the golden vector, with tag_ok=1 and err=0.
- Same vector with tag_exp bit 0 flipped → done with tag_ok=0 and err=0; pt_out is unchanged.
- Behavioral wrapper that never raises soc_ready, TIMEOUT=16 → done exactly 16 WAIT cycles in, with err=1, tag_ok=0 and zero soc_out_ss cycles.
- rst pulsed during READ at c=10 → no done pulse; all outputs are 0 and soc_rstn=0. A following request completes normally.
- start held high through two back-to-back operations → each operation is preceded by a 2-cycle soc_rstn low and produces exactly 1 done pulse. No start is accepted while busy=1.
